sha3_padder: RTL and testbench

- Upstream feeder for the SHA3-256 core (1088-bit rate, 256-bit digest).
- Accepts a message as a stream of 64-bit little-endian words with a last flag and byte count.
- Applies SHA3 domain padding (0x06 … 0x80) and packs 136-byte rate blocks.
- Issues blocks to the core's in / in_valid / more interface, pacing on the core's hash_next and out_valid.

---
 rtl/sha3_pkg.sv | 26 ++
 rtl/sha3_lane_pack.sv | 25 ++
 rtl/sha3_padder.sv | 133 +++++++++++++
 tb/tb_sha3_padder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared constants, FSM encoding and byte-placement helper for the SHA3-256 padder.
package sha3_pkg;

  localparam int unsigned RATE_BYTES      = 136;
  localparam int unsigned RATE_BITS       = 1088;
  localparam int unsigned WORD_BYTES      = 8;
  localparam int unsigned WORDS_PER_BLOCK = 17;

  localparam logic [7:0] DOMAIN_PAD_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_PAD_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_LAST         = 8'h80;

  typedef enum logic [1:0] {
    StFill,
    StIssue,
    StPadBlk
  } state_e;

  // Block with only byte `pos` set to `val`, stored bit-reversed as the core expects.
  function automatic logic [RATE_BITS-1:0] byte_at(input logic [7:0] pos, input logic [7:0] val);
    logic [7:0] rev;
    for (int b = 0; b < 8; b++) rev[7-b] = val[b];
    return {rev, {(RATE_BITS-8){1'b0}}} >> (8 * int'(pos));
  endfunction

endpackage

// File: rtl/sha3_lane_pack.sv
// Places one little-endian message word into its lane of a rate block, bit-reversing
// each byte and zeroing bytes at or beyond nbytes_i.
module sha3_lane_pack
  import sha3_pkg::*;
(
  input  logic [63:0]          word_i,
  input  logic [4:0]           word_idx_i,
  input  logic [3:0]           nbytes_i,
  output logic [RATE_BITS-1:0] block_o
);

  logic [63:0] rev;

  always_comb begin
    rev = '0;
    for (int k = 0; k < int'(WORD_BYTES); k++) begin
      if (k < int'(nbytes_i)) begin
        for (int b = 0; b < 8; b++) rev[63 - 8*k - b] = word_i[8*k + b];
      end
    end
  end

  assign block_o = {rev, {(RATE_BITS-64){1'b0}}} >> (64 * int'(word_idx_i));

endmodule

// File: rtl/sha3_padder.sv
// SHA3 padder: packs 64-bit message words into 1088-bit rate blocks, applies domain
// padding and paces block issue on the core's hash_next / out_valid.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter logic [7:0] DOMAIN_PAD = DOMAIN_PAD_SHA3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          din,
  input  logic                 din_valid,
  input  logic                 din_last,
  input  logic [3:0]           din_bytes,
  output logic                 din_ready,
  output logic [RATE_BITS-1:0] blk,
  output logic                 blk_valid,
  output logic                 blk_more,
  input  logic                 core_hash_next,
  input  logic                 core_out_valid
);

  state_e               state_q, state_d;
  logic [RATE_BITS-1:0] buf_q, buf_d;
  logic [4:0]           wcnt_q, wcnt_d;
  logic                 pad_pending_q, pad_pending_d;
  logic                 final_q, final_d;
  logic                 perm_q, perm_d;
  logic                 valid_q, valid_d;
  logic                 more_q, more_d;

  logic [3:0]           nbytes;
  logic [7:0]           pos;
  logic [RATE_BITS-1:0] placed;
  logic                 accept;

  // Oversized byte counts on the last word saturate to a full word.
  assign nbytes    = din_last ? ((din_bytes > 4'd8) ? 4'd8 : din_bytes) : 4'd8;
  assign pos       = {wcnt_q, 3'b000} + {4'b0000, nbytes};
  assign din_ready = (state_q == StFill) && !rst;
  assign accept    = din_valid && din_ready;

  sha3_lane_pack u_lane_pack (
    .word_i     (din),
    .word_idx_i (wcnt_q),
    .nbytes_i   (nbytes),
    .block_o    (placed)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    wcnt_d        = wcnt_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    valid_d       = 1'b0;
    more_d        = more_q;
    perm_d        = perm_q || core_hash_next || core_out_valid;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          buf_d = buf_q | placed;
          if (din_last) begin
            wcnt_d  = '0;
            state_d = StIssue;
            if (pos < 8'(RATE_BYTES)) begin
              buf_d   = buf_d ^ byte_at(pos, DOMAIN_PAD) ^ byte_at(8'(RATE_BYTES-1), PAD_LAST);
              final_d = 1'b1;
            end else begin
              final_d       = 1'b0;
              pad_pending_d = 1'b1;
            end
          end else if (wcnt_q == 5'(WORDS_PER_BLOCK-1)) begin
            wcnt_d  = '0;
            final_d = 1'b0;
            state_d = StIssue;
          end else begin
            wcnt_d = wcnt_q + 5'd1;
          end
        end
      end
      StIssue: begin
        // Buffer stays intact through the blk_valid cycle; it is released afterwards.
        if (valid_q) begin
          if (pad_pending_q) begin
            state_d = StPadBlk;
          end else begin
            buf_d   = '0;
            state_d = StFill;
          end
        end else if (perm_q) begin
          valid_d = 1'b1;
          more_d  = !final_q;
          perm_d  = 1'b0;
        end
      end
      StPadBlk: begin
        buf_d         = byte_at(8'd0, DOMAIN_PAD) ^ byte_at(8'(RATE_BYTES-1), PAD_LAST);
        pad_pending_d = 1'b0;
        final_d       = 1'b1;
        state_d       = StIssue;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFill;
      buf_q         <= '0;
      wcnt_q        <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      perm_q        <= 1'b1;
      valid_q       <= 1'b0;
      more_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      wcnt_q        <= wcnt_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      perm_q        <= perm_d;
      valid_q       <= valid_d;
      more_q        <= more_d;
    end
  end

  assign blk       = buf_q;
  assign blk_valid = valid_q;
  assign blk_more  = more_q;

endmodule

// File: tb/tb_sha3_padder.sv
// Randomized bench for sha3_padder: byte-level padding model, scoreboard of expected
// blocks and a simple core stand-in that answers each block with hash_next / out_valid.
module tb_sha3_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   din;
  logic          din_valid;
  logic          din_last;
  logic [3:0]    din_bytes;
  logic          din_ready;
  logic [1087:0] blk;
  logic          blk_valid;
  logic          blk_more;
  logic          core_hash_next;
  logic          core_out_valid;

  sha3_padder dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .din_valid      (din_valid),
    .din_last       (din_last),
    .din_bytes      (din_bytes),
    .din_ready      (din_ready),
    .blk            (blk),
    .blk_valid      (blk_valid),
    .blk_more       (blk_more),
    .core_hash_next (core_hash_next),
    .core_out_valid (core_out_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0]    msg[$];
  logic [1087:0] exp_blk_q[$];
  bit            exp_more_q[$];

  // Standard SHA3 padding on a byte array, then bit-reversed byte placement per block.
  task automatic model_push(input int len);
    int nblk;
    logic [7:0] p[];
    logic [1087:0] v;
    nblk = len / 136 + 1;
    p = new[nblk * 136];
    foreach (p[i]) p[i] = 8'h00;
    for (int i = 0; i < len; i++) p[i] = msg[i];
    p[len] = p[len] ^ 8'h06;
    p[nblk*136-1] = p[nblk*136-1] ^ 8'h80;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int k = 0; k < 136; k++)
        for (int j = 0; j < 8; j++) v[1087 - 8*k - j] = p[136*b + k][j];
      exp_blk_q.push_back(v);
      exp_more_q.push_back(b != nblk - 1);
    end
  endtask

  // Core stand-in
  int  core_cnt = -1;
  bit  core_more = 1'b0;
  bit  tb_perm = 1'b1;
  bit  withhold = 1'b0;
  bit  prev_valid = 1'b0;
  int  n_blk = 0;
  int  blk_cyc = 0;
  int  accept_cyc = 0;
  logic [1087:0] e_blk;
  bit  e_more;

  always @(negedge clk) begin
    core_hash_next = 1'b0;
    core_out_valid = 1'b0;
    if (!rst) begin
      if (core_cnt == 0) begin
        if (core_more) core_hash_next = 1'b1;
        else core_out_valid = 1'b1;
        tb_perm  = 1'b1;
        core_cnt = -1;
      end else if (core_cnt > 0) begin
        core_cnt--;
      end
      if (blk_valid) begin
        n_blk++;
        blk_cyc = cyc;
        check("blk_perm", 64'(tb_perm), 64'd1);
        check("blk_pulse", 64'(prev_valid), 64'd0);
        tb_perm = 1'b0;
        if (exp_blk_q.size() == 0) begin
          check("blk_extra", 64'd1, 64'd0);
        end else begin
          e_blk  = exp_blk_q.pop_front();
          e_more = exp_more_q.pop_front();
          for (int l = 0; l < 17; l++)
            check($sformatf("blk%0d_lane%0d", n_blk, l), blk[1087-64*l -: 64],
                  e_blk[1087-64*l -: 64]);
          check($sformatf("blk%0d_more", n_blk), 64'(blk_more), 64'(e_more));
        end
        core_more = blk_more;
        core_cnt  = withhold ? 50 : int'($urandom_range(1, 25));
      end
    end
    prev_valid = blk_valid;
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb,
                            input bit gaps);
    int budget = 2000;
    din_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    din       = d;
    din_last  = last;
    din_bytes = nb;
    din_valid = 1'b1;
    while (!din_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("ready_timeout", 64'd0, 64'd1);
    accept_cyc = cyc + 1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic send_msg(input int len, input bit gaps);
    int nw, nb;
    bit extra;
    logic [63:0] d;
    logic [3:0] bf;
    extra = (len % 8 == 0) && (len == 0 || $urandom_range(0, 1) == 1);
    nw = (len + 7) / 8 + (extra ? 1 : 0);
    for (int w = 0; w < nw; w++) begin
      d  = {$urandom, $urandom};
      nb = len - 8*w;
      if (nb > 8) nb = 8;
      if (nb < 0) nb = 0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8*w + k];
      if (w == nw - 1) bf = (nb == 8 && $urandom_range(0, 2) == 0) ?
                            4'($urandom_range(8, 15)) : 4'(nb);
      else bf = 4'($urandom_range(0, 15));
      drive_word(d, (w == nw - 1), bf, gaps);
    end
  endtask

  task automatic run_msg(input int len, input bit gaps);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    model_push(len);
    send_msg(len, gaps);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_blk_q.size() != 0 || core_cnt >= 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("idle_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    rst = 1'b1;
    din = '0; din_valid = 1'b0; din_last = 1'b0; din_bytes = '0;
    core_hash_next = 1'b0; core_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(din_ready), 64'd0);
    check("rst_valid", 64'(blk_valid), 64'd0);
    check("rst_more", 64'(blk_more), 64'd0);
    check("rst_blk", 64'(|blk), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(din_ready), 64'd1);

    // Empty message
    run_msg(0, 1'b1);
    wait_idle();

    // "abc" with issue latency
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    model_push(3);
    drive_word(64'hA5A5_A5A5_A563_6261, 1'b1, 4'd3, 1'b0);
    wait_idle();
    check("abc_latency", 64'(blk_cyc - accept_cyc), 64'd1);

    // 135 bytes (0x86 in last byte) and 136 bytes (separate pad block)
    run_msg(135, 1'b1);
    wait_idle();
    run_msg(136, 1'b1);
    wait_idle();

    // 300 bytes with continuation withheld: input must stall on the second full block
    withhold = 1'b1;
    base = n_blk;
    fork
      run_msg(300, 1'b0);
      begin
        t = 0;
        while (n_blk == base && t < 500) begin
          @(negedge clk);
          t++;
        end
        repeat (40) @(negedge clk);
        check("hold_ready", 64'(din_ready), 64'd0);
        check("hold_nblk", 64'(n_blk - base), 64'd1);
      end
    join
    wait_idle();
    withhold = 1'b0;

    // Back-to-back random messages
    for (int i = 0; i < 6; i++) run_msg(int'($urandom_range(0, 420)), ($urandom_range(0, 1) == 1));
    wait_idle();

    // Reset in the middle of a fill
    for (int i = 0; i < 5; i++) drive_word({$urandom, $urandom}, 1'b0, 4'd8, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(din_ready), 64'd0);
    check("mid_rst_valid", 64'(blk_valid), 64'd0);
    check("mid_rst_more", 64'(blk_more), 64'd0);
    check("mid_rst_blk", 64'(|blk), 64'd0);
    core_cnt = -1;
    tb_perm  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(din_ready), 64'd1);
    run_msg(21, 1'b0);
    wait_idle();
    check("post_rst_latency", 64'(blk_cyc - accept_cyc), 64'd1);

    check("sb_empty", 64'(exp_blk_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
